input_frame_ctrl: RTL and testbench

Input controller between the synchronized button/switch inputs and main_scene, running on the pixel clock domain.
- Debounces each input and detects press edges.
- Generates auto-repeat presses for selected inputs.
- Delivers one consolidated event word per video frame to the scene through a valid/ready handshake, so game state updates once per frame during vertical blanking.

---
 rtl/input_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 51 +++++
 rtl/input_frame_ctrl.sv | 113 +++++++++++
 tb/tb_input_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
// Package     : input_pkg
// Description : Button indices and default timing for the input controller.
// Revision    : 1.0 - initial release
// ============================================================================
package input_pkg;

    localparam int N_BTN = 9;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;
    localparam int BTN_1 = 5;
    localparam int BTN_2 = 6;
    localparam int BTN_3 = 7;
    localparam int BTN_4 = 8;

    // 10 ms of pclk at 25 MHz; repeat timing is counted in video frames
    localparam int               DEB_CYCLES_DEF = 250000;
    localparam logic [N_BTN-1:0] REP_MASK_DEF   = 9'b0_0000_1111;
    localparam int               REP_DELAY_DEF  = 20;
    localparam int               REP_PERIOD_DEF = 6;

    typedef logic [N_BTN-1:0] btn_vec_t;

endpackage : input_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Single-input debouncer; stable follows raw after DEB_CYCLES
//               consecutive differing cycles, rise pulses with each 0->1 step.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = input_pkg::DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int                 c_CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stable;
    logic               r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (raw != r_stable) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_stable <= raw;
                    r_cnt    <= '0;
                    r_rise   <= raw;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                // any return to the stable level restarts the count
                r_cnt <= '0;
            end
        end
    end

    assign stable = r_stable;
    assign rise   = r_rise;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/input_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : input_frame_ctrl
// Description : Debounced, auto-repeating button events delivered to the scene
//               once per frame through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module input_frame_ctrl
    import input_pkg::*;
#(
    parameter int               DEB_CYCLES = DEB_CYCLES_DEF,
    parameter logic [N_BTN-1:0] REP_MASK   = REP_MASK_DEF,
    parameter int               REP_DELAY  = REP_DELAY_DEF,
    parameter int               REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             frame_start,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [N_BTN-1:0] ev_press,
    output logic [N_BTN-1:0] ev_held,
    output logic             overrun
);

    localparam logic [8:0] c_REP_HIT    = 9'(REP_DELAY);
    localparam logic [7:0] c_REP_RELOAD = 8'(REP_DELAY - REP_PERIOD);

    logic [N_BTN-1:0] w_stable;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_rep;
    logic [N_BTN-1:0] w_set;
    logic             w_capture;

    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] r_ev_press;
    logic [N_BTN-1:0] r_ev_held;
    logic             r_ev_valid;
    logic             r_overrun;

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (btn_in[i]),
            .stable (w_stable[i]),
            .rise   (w_rise[i])
        );
    end

    // Frame-based repeat: counter restarts on the press edge, reloads on hit
    for (genvar i = 0; i < N_BTN; i++) begin : g_rep
        if (REP_MASK[i]) begin : g_on
            logic [7:0] r_rcnt;
            logic       w_hit;

            assign w_hit    = ({1'b0, r_rcnt} + 9'd1) == c_REP_HIT;
            assign w_rep[i] = frame_start & w_stable[i] & ~w_rise[i] & w_hit;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rcnt <= '0;
                end else if (!w_stable[i] || w_rise[i]) begin
                    r_rcnt <= '0;
                end else if (frame_start) begin
                    if (w_hit) begin
                        r_rcnt <= c_REP_RELOAD;
                    end else if (r_rcnt != 8'hFF) begin
                        r_rcnt <= r_rcnt + 8'd1;
                    end
                end
            end
        end else begin : g_off
            assign w_rep[i] = 1'b0;
        end
    end

    assign w_set     = w_rise | w_rep;
    assign w_capture = frame_start & (~r_ev_valid | ev_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_ev_press <= '0;
            r_ev_held  <= '0;
            r_ev_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_capture) begin
            // same-cycle edges/repeats go straight into this frame's word
            r_ev_press <= r_pending | w_set;
            r_ev_held  <= w_stable;
            r_ev_valid <= 1'b1;
            r_pending  <= '0;
        end else begin
            r_pending <= r_pending | w_set;
            if (frame_start) begin
                r_overrun <= 1'b1;
            end else if (ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_press = r_ev_press;
    assign ev_held  = r_ev_held;
    assign overrun  = r_overrun;

endmodule : input_frame_ctrl
`default_nettype wire

// File: tb/tb_input_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_frame_ctrl
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_frame_ctrl;

    localparam int         NB     = 9;
    localparam int         DEB    = 4;
    localparam int         RDELAY = 3;
    localparam int         RPER   = 2;
    localparam logic [8:0] RMASK  = 9'h00F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_in = '0;
    logic          frame_start = 1'b0;
    logic          ev_ready = 1'b1;
    logic          ev_valid;
    logic [NB-1:0] ev_press;
    logic [NB-1:0] ev_held;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    input_frame_ctrl #(
        .DEB_CYCLES (DEB),
        .REP_MASK   (RMASK),
        .REP_DELAY  (RDELAY),
        .REP_PERIOD (RPER)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .frame_start (frame_start),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_press    (ev_press),
        .ev_held     (ev_held),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit            use_model = 1'b0;
    logic [NB-1:0] m_stable, m_rise, m_pend, m_press, m_held;
    logic          m_valid, m_ov;
    int            m_run  [NB];
    int            m_fcnt [NB];   // frame_starts seen while held since the press

    task automatic model_reset();
        m_stable = '0; m_rise = '0; m_pend = '0; m_press = '0; m_held = '0;
        m_valid = 1'b0; m_ov = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
            m_fcnt[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [NB-1:0] rep, set;
        int n;
        rep = '0;
        for (int i = 0; i < NB; i++) begin
            if (RMASK[i] && frame_start && m_stable[i] && !m_rise[i]) begin
                n = m_fcnt[i] + 1;
                if (n >= RDELAY && ((n - RDELAY) % RPER) == 0) rep[i] = 1'b1;
            end
        end
        set = m_rise | rep;
        if (frame_start && (!m_valid || ev_ready)) begin
            m_press = m_pend | set;
            m_held  = m_stable;
            m_valid = 1'b1;
            m_pend  = '0;
        end else begin
            m_pend = m_pend | set;
            if (frame_start) m_ov = 1'b1;
            else if (m_valid && ev_ready) m_valid = 1'b0;
        end
        for (int i = 0; i < NB; i++) begin
            if (!m_stable[i] || m_rise[i]) m_fcnt[i] = 0;
            else if (frame_start) m_fcnt[i]++;
        end
        for (int i = 0; i < NB; i++) begin
            m_rise[i] = 1'b0;
            if (btn_in[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stable[i] = btn_in[i];
                    m_rise[i]   = btn_in[i];
                    m_run[i]    = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (use_model) model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn_in = '0; frame_start = 1'b0; ev_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [8:0] btn;
        logic       fs;
        logic       rdy;
        logic       valid;
        logic [8:0] press;
        logic [8:0] held;
        logic       ov;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [10:1] rep0_exp;
        logic [8:0]  exp_press;
        int          next_fs;

        // glitch/debounce/blocked-capture sequence on btn C, one record per cycle
        tbl[0]  = '{9'h000, 1'b1, 1'b1, 1'b1, 9'h000, 9'h000, 1'b0};
        tbl[1]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};
        tbl[2]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};
        tbl[3]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};
        tbl[4]  = '{9'h000, 1'b1, 1'b1, 1'b1, 9'h000, 9'h000, 1'b0};
        tbl[5]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};
        tbl[6]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};
        tbl[7]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};
        tbl[8]  = '{9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b0};
        tbl[9]  = '{9'h010, 1'b1, 1'b1, 1'b1, 9'h010, 9'h010, 1'b0};
        tbl[10] = '{9'h000, 1'b0, 1'b0, 1'b1, 9'h010, 9'h010, 1'b0};
        tbl[11] = '{9'h000, 1'b1, 1'b0, 1'b1, 9'h010, 9'h010, 1'b1};
        tbl[12] = '{9'h000, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1};
        tbl[13] = '{9'h000, 1'b0, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1};
        tbl[14] = '{9'h000, 1'b1, 1'b1, 1'b1, 9'h000, 9'h000, 1'b1};

        // ---- reset state ----
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_valid", {8'd0, ev_valid}, 9'h000);
        check("rst_press", ev_press, 9'h000);
        check("rst_held",  ev_held,  9'h000);
        check("rst_overrun", {8'd0, overrun}, 9'h000);

        // ---- vector table ----
        do_reset();
        for (int v = 0; v < 15; v++) begin
            btn_in = tbl[v].btn; frame_start = tbl[v].fs; ev_ready = tbl[v].rdy;
            tick();
            check($sformatf("tbl%0d_valid", v), {8'd0, ev_valid}, {8'd0, tbl[v].valid});
            check($sformatf("tbl%0d_overrun", v), {8'd0, overrun}, {8'd0, tbl[v].ov});
            if (tbl[v].valid) begin
                check($sformatf("tbl%0d_press", v), ev_press, tbl[v].press);
                check($sformatf("tbl%0d_held", v), ev_held, tbl[v].held);
            end
        end
        frame_start = 1'b0;

        // ---- auto-repeat on U (masked) and sw0 (unmasked), held 10 frames ----
        do_reset();
        rep0_exp = 10'b01_0101_0101;   // frames 1,3,5,7,9
        btn_in = 9'h021;
        repeat (6) tick();
        for (int k = 1; k <= 10; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            exp_press = '0;
            exp_press[0] = rep0_exp[k];
            exp_press[5] = (k == 1);
            check($sformatf("rep_f%0d_valid", k), {8'd0, ev_valid}, 9'h001);
            check($sformatf("rep_f%0d_press", k), ev_press, exp_press);
            check($sformatf("rep_f%0d_held", k), ev_held, 9'h021);
            repeat (7) tick();
        end

        // ---- overrun: two blocked frames while D is pressed ----
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        ev_ready = 1'b0; btn_in = 9'h002;
        repeat (6) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("ovr_flag1", {8'd0, overrun}, 9'h001);
        check("ovr_hold_valid", {8'd0, ev_valid}, 9'h001);
        check("ovr_hold_press1", ev_press, 9'h000);
        repeat (3) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("ovr_hold_press2", ev_press, 9'h000);
        btn_in = '0; ev_ready = 1'b1;
        tick();
        check("ovr_consumed", {8'd0, ev_valid}, 9'h000);
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("ovr_late_valid", {8'd0, ev_valid}, 9'h001);
        check("ovr_late_press", ev_press, 9'h002);
        check("ovr_late_held", ev_held, 9'h002);
        check("ovr_sticky", {8'd0, overrun}, 9'h001);

        // ---- asynchronous reset with a pending press and a debounce in flight ----
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        ev_ready = 1'b0; btn_in = 9'h004;
        repeat (5) tick();
        btn_in = 9'h044;
        repeat (2) tick();
        check("arst_pre_valid", {8'd0, ev_valid}, 9'h001);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", {8'd0, ev_valid}, 9'h000);
        check("arst_press", ev_press, 9'h000);
        check("arst_overrun", {8'd0, overrun}, 9'h000);
        btn_in = '0; ev_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("arst_first_valid", {8'd0, ev_valid}, 9'h001);
        check("arst_first_press", ev_press, 9'h000);
        check("arst_first_held", ev_held, 9'h000);

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        use_model = 1'b1;
        next_fs = $urandom_range(8, 20);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_in[$urandom_range(0, NB-1)] ^= 1'b1;
            ev_ready = ($urandom_range(0, 3) != 0);
            next_fs--;
            frame_start = (next_fs == 0);
            if (next_fs == 0) next_fs = $urandom_range(8, 20);
            tick();
            check($sformatf("rnd%0d_valid", c), {8'd0, ev_valid}, {8'd0, m_valid});
            check($sformatf("rnd%0d_overrun", c), {8'd0, overrun}, {8'd0, m_ov});
            if (m_valid) begin
                check($sformatf("rnd%0d_press", c), ev_press, m_press);
                check($sformatf("rnd%0d_held", c), ev_held, m_held);
            end
        end
        use_model = 1'b0;
        frame_start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_input_frame_ctrl
`default_nettype wire
